// File: rtl/shift_left_sequential_pkg.sv
// Shared definitions for the sequential shifter family: default widths and FSM state codes.
package shift_left_sequential_pkg;

    localparam int unsigned SHL_WIDTH   = 32;
    localparam int unsigned SHL_SHAMT_W = 5;

    // 2'b11 is unused and recovers to SHL_IDLE
    typedef enum logic [1:0] {
        SHL_IDLE  = 2'd0,
        SHL_SHIFT = 2'd1,
        SHL_DONE  = 2'd2
    } shl_state_e;

endpackage

// File: rtl/shift_left_sequential_if.sv
// Start/operand/result bundle between a shift requester (master) and the shifter (slave).
interface shift_left_sequential_if
    import shift_left_sequential_pkg::*;
#(
    parameter int unsigned WIDTH   = SHL_WIDTH,
    parameter int unsigned SHAMT_W = SHL_SHAMT_W
);

    logic               start;
    logic [WIDTH-1:0]   in;
    logic [SHAMT_W-1:0] shift_amt;
    logic [WIDTH-1:0]   out;
    logic               busy;
    logic               done;

    modport master (
        output start, in, shift_amt,
        input  out, busy, done
    );

    modport slave (
        input  start, in, shift_amt,
        output out, busy, done
    );

endinterface

// File: rtl/shift_left_sequential.sv
// Multi-cycle logical left shifter: one bit position per clock, done pulse on completion.
module shift_left_sequential
    import shift_left_sequential_pkg::*;
#(
    parameter int unsigned WIDTH   = SHL_WIDTH,
    parameter int unsigned SHAMT_W = SHL_SHAMT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    shift_left_sequential_if.slave   bus
);

    // Shift amount must exactly address every bit position
    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt_w
        $error("SHAMT_W must equal clog2(WIDTH)");
    end

    shl_state_e         state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, done_q;

    // Next-state, datapath and counter update
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            SHL_IDLE, SHL_DONE: begin
                if (bus.start) begin
                    out_d   = bus.in;
                    cnt_d   = bus.shift_amt;
                    state_d = (bus.shift_amt == '0) ? SHL_DONE : SHL_SHIFT;
                end else begin
                    state_d = SHL_IDLE;
                end
            end
            SHL_SHIFT: begin
                // cnt_q is at least 1 here, so the decrement cannot wrap
                out_d = {out_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = SHL_DONE;
                end
            end
            default: begin
                state_d = SHL_IDLE;
            end
        endcase
    end

    // State, datapath and status registers; status flags track the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHL_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == SHL_SHIFT);
            done_q  <= (state_d == SHL_DONE);
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_left_sequential.sv
// Directed testbench for shift_left_sequential with hand-computed expectations.
module tb_shift_left_sequential;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    shift_left_sequential_if bus ();

    shift_left_sequential dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one start, then count edges until done; optionally scramble inputs while shifting
    task automatic do_op(input logic [31:0] a, input logic [4:0] amt, input bit scramble,
                         output int lat, output int busy_cnt);
        bus.start     = 1'b1;
        bus.in        = a;
        bus.shift_amt = amt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            if (scramble) begin
                bus.start     = 1'($urandom);
                bus.in        = $urandom;
                bus.shift_amt = 5'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
    endtask

    int lat;
    int bcnt;
    int seen_done;

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in        = '0;
        bus.shift_amt = '0;

        // Reset state, during and after release
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",  bus.out, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_out",  bus.out, 32'h0);
        check("idle_done", 32'(bus.done), 32'h0);

        // 1 << 5
        do_op(32'h0000_0001, 5'd5, 1'b0, lat, bcnt);
        check("op5_out",  bus.out, 32'h0000_0020);
        check("op5_lat",  32'(lat), 32'd5);
        check("op5_busy", 32'(bcnt), 32'd5);
        @(posedge clk); #1;
        check("op5_pulse", 32'(bus.done), 32'h0);
        check("op5_hold",  bus.out, 32'h0000_0020);

        // Zero shift: one-cycle latency, never busy
        do_op(32'hDEAD_BEEF, 5'd0, 1'b0, lat, bcnt);
        check("op0_out",  bus.out, 32'hDEAD_BEEF);
        check("op0_lat",  32'(lat), 32'd0);
        check("op0_busy", 32'(bcnt), 32'd0);
        @(posedge clk); #1;
        check("op0_pulse", 32'(bus.done), 32'h0);

        // Maximum shift with inputs toggled while busy
        do_op(32'hFFFF_FFFF, 5'd31, 1'b1, lat, bcnt);
        check("op31_out",  bus.out, 32'h8000_0000);
        check("op31_lat",  32'(lat), 32'd31);
        check("op31_busy", 32'(bcnt), 32'd31);
        @(posedge clk); #1;
        check("op31_pulse", 32'(bus.done), 32'h0);
        check("op31_hold",  bus.out, 32'h8000_0000);

        // Back-to-back: second start accepted in the DONE cycle
        do_op(32'h0000_0001, 5'd2, 1'b0, lat, bcnt);
        check("b2b_first", bus.out, 32'h0000_0004);
        do_op(32'h0000_0003, 5'd4, 1'b0, lat, bcnt);
        check("b2b_out",  bus.out, 32'h0000_0030);
        check("b2b_lat",  32'(lat), 32'd4);
        check("b2b_busy", 32'(bcnt), 32'd4);
        @(posedge clk); #1;

        // Reset mid-shift aborts with no done pulse
        bus.start     = 1'b1;
        bus.in        = 32'h0000_0001;
        bus.shift_amt = 5'd20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        check("mid_out", bus.out, 32'h0000_0080);
        rst_n = 1'b0;
        #1;
        check("abort_out",  bus.out, 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        seen_done = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen_done++;
        end
        check("abort_quiet", 32'(seen_done), 32'h0);

        // Normal operation after abort
        do_op(32'h0000_00F0, 5'd8, 1'b0, lat, bcnt);
        check("post_out", bus.out, 32'h0000_F000);
        check("post_lat", 32'(lat), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_left_sequential.md
Name: shift_left_sequential

Overview:
- Multi-cycle logical left shifter for the ALU shift path. It is the left-direction counterpart of the combinational arithmetic right shifter.
- Captures an operand and shift amount on a start handshake, then shifts one bit position per clock.
- Signals completion with a single-cycle done pulse and holds the result until the next accepted start.
- Trades the 32-mux barrel structure for a small counter plus FSM, for area-constrained builds.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block is ready (IDLE or DONE).
- in  input  WIDTH  operand, captured on the accepted start.
- shift_amt  input  SHAMT_W  shift distance 0..WIDTH-1, captured on the accepted start.
- out  output  WIDTH  result register, equal to in << shift_amt, zero-filled from the LSB side.
- busy  output  1  high while in SHIFT; start is ignored while busy.
- done  output  1  one-cycle pulse when out holds the final result.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out=0, cnt=0, busy=0, done=0. Reset mid-operation aborts immediately, with no done pulse.
- States: IDLE, SHIFT, DONE. Encoding is 2-bit binary; code 2'b11 is illegal and must recover to IDLE.
- IDLE or DONE with start=1 (accepted at edge T):
  - out<=in and cnt<=shift_amt.
  - If shift_amt==0, next state is DONE; otherwise next state is SHIFT.
- IDLE with start=0: stay in IDLE; out holds.
- SHIFT, each cycle:
  - out<=out<<1, with bit 0 filled with 0; cnt<=cnt-1.
  - If cnt==1, next state is DONE; otherwise stay in SHIFT.
  - start is ignored; in and shift_amt may change without effect.
- DONE: done=1 for exactly this cycle.
  - With start=0: next state is IDLE.
  - With start=1: accepted as from IDLE, giving back-to-back operation with no bubble.
- Outputs: busy=(state==SHIFT) and done=(state==DONE), both decoded from registered state (no combinational path from inputs).
- Latency: done is high in cycle T+N+1 for shift amount N.
  - N=0 gives 1 cycle; N=31 gives 32 cycles.
  - Throughput is one operation per N+1 cycles.
- out is valid only while done=1 and thereafter until the next accepted start. Intermediate values are visible during SHIFT.
- Width rule: bits shifted past the MSB are discarded. No sign or arithmetic handling; that is the right-shifter's job.
- cnt never underflows: the decrement occurs only in SHIFT, where cnt>=1.

Decomposition:
- Shared ALU package holds:
  - the state localparams SHL_IDLE=2'd0, SHL_SHIFT=2'd1, SHL_DONE=2'd2;
  - the WIDTH/SHAMT_W defaults, shared with the shifter family.
- No sub-module is required. The down-counter may optionally be factored as shift_counter (load, dec, zero-detect) if it is reused by a future sequential right shifter.

Test Plan:
- Reset in IDLE, then release → out=32'h0, busy=0, done=0, state IDLE.
- start, in=32'h0000_0001, shift_amt=5 → busy for 5 cycles, done in cycle T+6, out=32'h0000_0020.
- start, in=32'hDEAD_BEEF, shift_amt=0 → done in cycle T+1, out=32'hDEAD_BEEF, busy never asserted.
- start, in=32'hFFFF_FFFF, shift_amt=31 → done in cycle T+32, out=32'h8000_0000. Toggling start/in during SHIFT has no effect.
- Back-to-back: start held high in the DONE cycle with in=32'h0000_0003, shift_amt=4 → second done 5 cycles later, out=32'h0000_0030, with no IDLE cycle between.
- rst_n pulsed low mid-SHIFT (in=32'h1, amt=20, after 7 cycles) → out=0, busy=0 immediately. No done pulse follows; next start operates normally.
